// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the sram-like 2:1 arbiter.
package sram_arb_pkg;

  // Owner tags stored in the outstanding-request FIFO
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Arbiter FSM states
  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // sram-like transfer sizes
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Request payload carried from a master to the slave port
  typedef struct packed {
    logic        wr;
    size_e       size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/tag_fifo.sv
// One-bit-wide owner-tag FIFO tracking accepted-but-unanswered requests.
module tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic full_c,
  output logic empty_c,
  output logic head_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Status decode from the registered count and head entry
  always_comb begin
    full_c  = (cnt_q == CW'(DEPTH));
    empty_c = (cnt_q == '0);
    head_c  = mem_q[rd_ptr_q];
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    do_push  = push & ~full_c;
    do_pop   = pop & ~empty_c;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO registers with synchronous clear
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q    <= {DEPTH{OWN_INST}};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_like_arb.sv
// 2:1 sram-like arbiter: inst fetch (m0) and load/store (m1) onto one slave port.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; default is
// fixed priority with m1 over m0.
module sram_like_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
`ifdef SRAM_ARB_RR_EN
  logic       last_q, last_d;
`endif

  logic      pick, grant, gnt_req, accept, pop;
  logic      fifo_full, fifo_empty, fifo_head;
  sram_req_t m0_pl, m1_pl, s_pl;

  // Pack master request fields
  always_comb begin
    m0_pl = '{wr: m0_wr, size: size_e'(m0_size), addr: m0_addr,
              wstrb: m0_wstrb, wdata: m0_wdata};
    m1_pl = '{wr: m1_wr, size: size_e'(m1_size), addr: m1_addr,
              wstrb: m1_wstrb, wdata: m1_wdata};
  end

  // Arbitration choice used while idle
  always_comb begin
`ifdef SRAM_ARB_RR_EN
    pick = (m0_req & m1_req) ? ~last_q : m1_req;
`else
    pick = m1_req ? OWN_DATA : OWN_INST;
`endif
  end

  // Request path: grant is frozen in HOLD so the slave sees a stable request
  always_comb begin
    grant      = (state_q == ARB_HOLD) ? grant_q : pick;
    gnt_req    = (grant == OWN_DATA) ? m1_req : m0_req;
    s_pl       = (grant == OWN_DATA) ? m1_pl : m0_pl;
    s_req      = resetn & gnt_req & ~fifo_full;
    accept     = s_req & s_addr_ok;
    m0_addr_ok = accept & (grant == OWN_INST);
    m1_addr_ok = accept & (grant == OWN_DATA);
    s_wr       = s_pl.wr;
    s_size     = s_pl.size;
    s_addr     = s_pl.addr;
    s_wstrb    = s_pl.wstrb;
    s_wdata    = s_pl.wdata;
  end

  // Response path: FIFO head names the owner of each in-order data_ok
  always_comb begin
    pop        = resetn & s_data_ok & ~fifo_empty;
    m0_data_ok = pop & (fifo_head == OWN_INST);
    m1_data_ok = pop & (fifo_head == OWN_DATA);
    m0_rdata   = s_rdata;
    m1_rdata   = s_rdata;
  end

  // Next-state: enter HOLD on a stalled request, leave once it is accepted
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
`ifdef SRAM_ARB_RR_EN
    last_d  = last_q;
    if (accept) last_d = grant;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (s_req & ~s_addr_ok) begin
          state_d = ARB_HOLD;
          grant_d = grant;
        end
      end
      ARB_HOLD: begin
        if (s_addr_ok | ~s_req) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers; after reset round-robin favours m0
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= OWN_INST;
`ifdef SRAM_ARB_RR_EN
      last_q  <= OWN_DATA;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef SRAM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .pop     (pop),
    .din     (grant),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .head_c  (fifo_head)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is a slave protocol error
  always_ff @(posedge clk) begin
    if (resetn && s_data_ok) begin
      assert (!fifo_empty)
        else $error("sram_like_arb: s_data_ok with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_sram_like_arb.sv
// Scoreboard bench for sram_like_arb: stimulus queues expected accepts and
// responses, a negedge monitor pops and compares whenever the DUT handshakes.
`timescale 1ns/1ps
module tb_sram_like_arb;

  localparam int unsigned DEPTH = 4;

  logic        clk, resetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_addr_ok, s_data_ok;

  sram_like_arb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   n_cmp = 0;
  int   n_err = 0;
  acc_t mon_a;
  rsp_t mon_r;
  logic mon_own;
  logic first;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Bench-defined write data pattern per master
  function automatic logic [31:0] wd(input logic m, input logic [31:0] a);
    return a ^ (m ? 32'h1111_1111 : 32'h2222_2222);
  endfunction

  // m0 does word accesses, m1 byte accesses
  task automatic set_m(input logic m, input logic req, input logic wr, input logic [31:0] addr);
    if (m) begin
      m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wd(1'b1, addr);
      m1_size = 2'd0; m1_wstrb = wr ? 4'h1 : 4'h0;
    end else begin
      m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wd(1'b0, addr);
      m0_size = 2'd2; m0_wstrb = wr ? 4'hF : 4'h0;
    end
  endtask

  task automatic expect_req(input logic m, input logic wr, input logic [31:0] addr,
                            input logic [31:0] rdata);
    acc_t a;
    rsp_t r;
    a.owner = m; a.wr = wr; a.size = m ? 2'd0 : 2'd2;
    a.wstrb = wr ? (m ? 4'h1 : 4'hF) : 4'h0;
    a.addr = addr; a.wdata = wd(m, addr);
    r.owner = m; r.rdata = rdata;
    exp_acc.push_back(a);
    exp_rsp.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input logic [31:0] rdata);
    s_data_ok = 1'b1;
    s_rdata   = rdata;
    step();
    s_data_ok = 1'b0;
    s_rdata   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_s_req"}, 32'(s_req), 32'd0);
    check({tag, "_m0_addr_ok"}, 32'(m0_addr_ok), 32'd0);
    check({tag, "_m1_addr_ok"}, 32'(m1_addr_ok), 32'd0);
    check({tag, "_m0_data_ok"}, 32'(m0_data_ok), 32'd0);
    check({tag, "_m1_data_ok"}, 32'(m1_data_ok), 32'd0);
  endtask

  // Monitor: compare every DUT handshake against the scoreboard queues
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (m0_addr_ok && m1_addr_ok) begin
        n_cmp++; n_err++;
        $display("FAIL dual_addr_ok: got both high required one (t=%0t)", $time);
      end else if (m0_addr_ok || m1_addr_ok) begin
        mon_own = m1_addr_ok;
        if (exp_acc.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_addr_ok: got owner %0d required none (t=%0t)", mon_own, $time);
        end else begin
          mon_a = exp_acc.pop_front();
          check("acc_owner", 32'(mon_own), 32'(mon_a.owner));
          check("s_addr", s_addr, mon_a.addr);
          check("s_wr", 32'(s_wr), 32'(mon_a.wr));
          check("s_size", 32'(s_size), 32'(mon_a.size));
          check("s_wstrb", 32'(s_wstrb), 32'(mon_a.wstrb));
          check("s_wdata", s_wdata, mon_a.wdata);
        end
      end
      if (m0_data_ok && m1_data_ok) begin
        n_cmp++; n_err++;
        $display("FAIL dual_data_ok: got both high required one (t=%0t)", $time);
      end else if (m0_data_ok || m1_data_ok) begin
        mon_own = m1_data_ok;
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_data_ok: got owner %0d required none (t=%0t)", mon_own, $time);
        end else begin
          mon_r = exp_rsp.pop_front();
          check("rsp_owner", 32'(mon_own), 32'(mon_r.owner));
          check("rsp_rdata", mon_own ? m1_rdata : m0_rdata, mon_r.rdata);
        end
      end
    end
  end

  // Stimulus
  initial begin
    resetn = 1'b0;
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;

    // Reset with busy inputs: all handshakes must be suppressed
    set_m(1'b0, 1'b1, 1'b0, 32'h1C00_0000);
    set_m(1'b1, 1'b1, 1'b0, 32'h0000_0100);
    s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    check_reset_outputs("rst0");
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    resetn = 1'b1;

    // Both request once: winner first, loser on the next acceptance
`ifdef SRAM_ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    set_m(1'b1, 1'b1, 1'b0, 32'h0000_0100);
    s_addr_ok = 1'b1;
    expect_req(first, 1'b0, first ? 32'h100 : 32'h200, 32'h11);
    expect_req(~first, 1'b0, first ? 32'h200 : 32'h100, 32'h22);
    step();
    set_m(first, 1'b0, 1'b0, 32'h0);
    step();
    set_m(~first, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    respond(32'h11);
    respond(32'h22);

    // Continuous dual requests for four acceptances, then FIFO full
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_0300);
    set_m(1'b1, 1'b1, 1'b0, 32'h0000_0400);
    s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_RR_EN
      first = (i % 2 == 1);
`else
      first = 1'b1;
`endif
      expect_req(first, 1'b0, first ? 32'h400 : 32'h300, 32'h30 + 32'(i));
    end
    repeat (4) step();
    @(negedge clk);
    check("dual_full_s_req", 32'(s_req), 32'd0);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) respond(32'h30 + 32'(i));

    // Single inst read, response two cycles after acceptance
    set_m(1'b0, 1'b1, 1'b0, 32'h1C00_0000);
    s_addr_ok = 1'b1;
    expect_req(1'b0, 1'b0, 32'h1C00_0000, 32'h0280_0000);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    step();
    respond(32'h0280_0000);

    // Stall: m0 held three cycles while m1 rises mid-stall
    set_m(1'b0, 1'b1, 1'b0, 32'h0000_1000);
    s_addr_ok = 1'b0;
    expect_req(1'b0, 1'b0, 32'h1000, 32'h51);
    expect_req(1'b1, 1'b0, 32'h2000, 32'h52);
    @(negedge clk);
    check("stall0_s_addr", s_addr, 32'h1000);
    step();
    set_m(1'b1, 1'b1, 1'b0, 32'h0000_2000);
    @(negedge clk);
    check("stall1_s_addr", s_addr, 32'h1000);
    check("stall1_s_req", 32'(s_req), 32'd1);
    step();
    @(negedge clk);
    check("stall2_s_addr", s_addr, 32'h1000);
    step();
    s_addr_ok = 1'b1;
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    respond(32'h51);
    respond(32'h52);

    // Five requests with responses withheld: fifth waits for a pop
    s_addr_ok = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_req(1'b0, 1'b0, 32'h40 + 32'(4 * i), 32'h60 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      set_m(1'b0, 1'b1, 1'b0, 32'h40 + 32'(4 * i));
      step();
    end
    set_m(1'b0, 1'b1, 1'b0, 32'h50);
    @(negedge clk);
    check("full_a_s_req", 32'(s_req), 32'd0);
    step();
    @(negedge clk);
    check("full_b_s_req", 32'(s_req), 32'd0);
    step();
    s_data_ok = 1'b1;
    s_rdata   = 32'h60;
    @(negedge clk);
    check("full_pop_s_req", 32'(s_req), 32'd0);
    step();
    s_data_ok = 1'b0;
    s_rdata   = '0;
    @(negedge clk);
    check("after_pop_s_req", 32'(s_req), 32'd1);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    for (int i = 1; i < 5; i++) respond(32'h60 + 32'(i));

    // Interleaved owners 0,1,1,0 with writes and a same-cycle push/pop
    s_addr_ok = 1'b1;
    expect_req(1'b0, 1'b0, 32'h0A00, 32'hA);
    expect_req(1'b1, 1'b1, 32'h0B00, 32'hB);
    expect_req(1'b1, 1'b0, 32'h0B04, 32'hC);
    expect_req(1'b0, 1'b1, 32'h0A04, 32'hD);
    set_m(1'b0, 1'b1, 1'b0, 32'h0A00);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1'b1, 1'b1, 1'b1, 32'h0B00);
    s_data_ok = 1'b1;
    s_rdata   = 32'hA;
    step();
    s_data_ok = 1'b0;
    s_rdata   = '0;
    set_m(1'b1, 1'b1, 1'b0, 32'h0B04);
    step();
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    set_m(1'b0, 1'b1, 1'b1, 32'h0A04);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    respond(32'hB);
    respond(32'hC);
    respond(32'hD);

    // Reset with two tags outstanding (m1 then m0); they are discarded
    s_addr_ok = 1'b1;
    expect_req(1'b1, 1'b0, 32'h0C00, 32'h0);
    expect_req(1'b0, 1'b0, 32'h0C04, 32'h0);
    set_m(1'b1, 1'b1, 1'b0, 32'h0C00);
    step();
    set_m(1'b1, 1'b0, 1'b0, 32'h0);
    set_m(1'b0, 1'b1, 1'b0, 32'h0C04);
    step();
    resetn = 1'b0;
    set_m(1'b0, 1'b1, 1'b0, 32'h0D00);
    s_data_ok = 1'b1;
    s_rdata   = 32'hEE;
    check_reset_outputs("rst1");
    step();
    resetn    = 1'b1;
    s_data_ok = 1'b0;
    s_rdata   = '0;
    exp_rsp.delete();
    expect_req(1'b0, 1'b0, 32'h0D00, 32'h77);
    step();
    set_m(1'b0, 1'b0, 1'b0, 32'h0);
    s_addr_ok = 1'b0;
    respond(32'h77);

    repeat (2) step();
    check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
    check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Bound the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_like_arb.md
# sram_like_arb

Two-to-one arbiter for the CPU's sram-like memory interfaces. It merges the instruction-fetch channel (master 0) and the load/store channel (master 1) onto one shared sram-like slave port. It sits between `mycpu_top`'s inst/data sram ports and the single memory or bridge port. It tracks outstanding requests in an owner-tag FIFO so each in-order `data_ok`/`rdata` is returned to the master that issued it.

## Interface
Parameters:
- `DEPTH`, 4: maximum accepted-but-unanswered requests (power of two, 2..16).

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: synchronous, active-low reset.
- `m0_req`, `m1_req` in 1: master request valid.
- `m0_wr`, `m1_wr` in 1: 1 = write.
- `m0_size`, `m1_size` in 2: 0 = byte, 1 = half, 2 = word.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wstrb`, `m1_wstrb` in 4: byte write enables.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_addr_ok`, `m1_addr_ok` out 1: request accepted this cycle.
- `m0_data_ok`, `m1_data_ok` out 1: response for this master this cycle.
- `m0_rdata`, `m1_rdata` out 32: read data; both equal `s_rdata`.
- `s_req`, `s_wr`, `s_size`, `s_addr`, `s_wstrb`, `s_wdata` out 1/1/2/32/4/32: request forwarded to the slave.
- `s_addr_ok`, `s_data_ok` in 1: slave handshakes.
- `s_rdata` in 32: slave read data.

## Operation
- Two-state FSM.
  - IDLE: the grant is chosen combinationally among masters with `req` high.
  - HOLD: the grant is latched. The FSM enters HOLD when `s_req` is high and `s_addr_ok` is low. It returns to IDLE on the cycle `s_addr_ok` is high. The grant never changes while in HOLD, because sram-like requires the request to stay stable until it is accepted.
- Arbitration policy: fixed priority, master 1 (data) over master 0. See Configuration for the alternative.
- `s_*` request fields are muxed from the granted master.
- `s_req` is the granted master's `req` AND not full.
- Acceptance: on `s_req & s_addr_ok`, the granted master's `addr_ok` is 1 and the owner tag (0/1) is pushed into the FIFO.
- Response: on `s_data_ok`, the FIFO head tag selects which `mX_data_ok` pulses, and the head is popped. Writes also consume one `data_ok`.
- Full (count == `DEPTH`):
  - `s_req` is 0 and no grant is issued, even if a pop occurs in the same cycle.
  - HOLD cannot coexist with full, because acceptance is what fills the FIFO.
- Empty with `s_data_ok` high: protocol error. No master `data_ok` is driven, count stays 0, and a simulation-only assertion fires.
- Push and pop in the same cycle: count is unchanged, head and tail both advance.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset (`resetn` low at a `clk` edge):
  - FSM returns to IDLE; FIFO pointers and count are cleared; the round-robin pointer selects master 0.
  - While `resetn` is low, `s_req`, `m0/1_addr_ok` and `m0/1_data_ok` are forced to 0.
  - Reset mid-transaction discards all outstanding tags; the slave is reset in the same cycle by the system.
- Latency:
  - Request path: zero-cycle combinational from `mX_req` to `s_req`, and from `s_addr_ok` to `mX_addr_ok`.
  - Response path: zero-cycle combinational from `s_data_ok` to `mX_data_ok`.
  - The arbiter adds no extra cycles of its own.
- Back-to-back: one acceptance per cycle is possible. A master whose `addr_ok` is high may present a new request in the following cycle.
- Tag push and pop take effect at the next `clk` edge. A request accepted in cycle N may have its `data_ok` in cycle N+1 at the earliest.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin.
  - When both masters request in IDLE, the master not granted last wins.
  - The pointer updates only on acceptance.
- `SRAM_ARB_RR_EN` undefined: fixed priority, with master 1 (data) over master 0.

## Structure
- Shared package `sram_arb_pkg` holds:
  - owner tag constants `OWN_INST=1'b0`, `OWN_DATA=1'b1`;
  - FSM state encodings `ARB_IDLE`, `ARB_HOLD`;
  - size encodings.
- One sub-module, `tag_fifo`:
  - synchronous FIFO, 1-bit wide, depth `DEPTH`;
  - push/pop/full/empty/head outputs;
  - same `clk`/`resetn`.

## Test plan
- Single inst read to address 0x1C000000, with `s_addr_ok` in the same cycle and `s_data_ok` 2 cycles later carrying 0x02800000.
  Expect `m0_addr_ok` for 1 cycle, then `m0_data_ok` with `m0_rdata` = 0x02800000, and `m1_data_ok` staying 0.
- Both masters request in the same cycle.
  - Fixed priority: `m1` is granted first and `m0` on the next acceptance.
  - `SRAM_ARB_RR_EN`: grants alternate 0,1,0,1 over four cycles of continuous requests.
- `s_addr_ok` held low for 3 cycles while `m1_req` rises mid-stall after `m0` was granted.
  Expect `s_addr` to stay at m0's address until acceptance, and `m1` to be served afterwards.
- `DEPTH`=4 with `s_data_ok` withheld and 5 requests presented.
  Expect 4 `addr_ok` pulses, then `s_req` low. After one `s_data_ok`, the fifth request is accepted.
- Interleaved owners (tag order 0,1,1,0) with 4 responses returning 0xA, 0xB, 0xC, 0xD.
  Expect `data_ok` to go to m0, m1, m1, m0, with matching data.
- `resetn` low for 1 cycle while 2 requests are outstanding.
  Expect all handshake outputs 0 during reset, count 0 afterwards, and a subsequent request served normally.
